// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register chain: DEPTH valid/ready stages, each with a skid buffer.
// Upstream ready depends only on registered skid state, so out_ready never reaches in_ready combinationally.
module pipe_stage_elastic #(
   parameter int DATA_W     = 64,
   parameter int DEPTH      = 1,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_W-1:0]              in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_W-1:0]              out_data,
   output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(2*DEPTH+1);

   logic [DEPTH-1:0]  mv;
   logic [DEPTH-1:0]  sv;
   logic [DEPTH-1:0]  v_up;
   logic [DEPTH-1:0]  r_dn;
   logic [DATA_W-1:0] md   [DEPTH];
   logic [DATA_W-1:0] d_up [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic              mv_q, sv_q;
      logic [DATA_W-1:0] md_q, sd_q;
      logic              accept, pop;
      logic              md_load_up, md_load_skid, sd_load;

      if (k == 0) begin : g_head
         assign v_up[k] = in_valid;
         assign d_up[k] = in_data;
      end else begin : g_link
         assign v_up[k] = mv[k-1];
         assign d_up[k] = md[k-1];
      end

      if (k == DEPTH-1) begin : g_tail
         assign r_dn[k] = out_ready;
      end else begin : g_inner
         assign r_dn[k] = !sv[k+1];
      end

      assign accept       = v_up[k] && !sv_q;
      assign pop          = mv_q && r_dn[k];
      assign md_load_up   = accept && (!mv_q || pop);
      assign md_load_skid = pop && sv_q;
      assign sd_load      = accept && mv_q && !pop;

      // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values of its neighbours.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mv_q <= 1'b0;
            sv_q <= 1'b0;
         end else if (flush) begin
            mv_q <= 1'b0;
            sv_q <= 1'b0;
         end else begin
            mv_q <= sv_q || (mv_q && !pop) || accept;
            sv_q <= (sv_q && !pop) || sd_load;
         end
      end

      if (CLEAR_DATA) begin : g_clear
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               md_q <= '0;
               sd_q <= '0;
            end else if (flush) begin
               md_q <= '0;
               sd_q <= '0;
            end else begin
               if (md_load_up)        md_q <= d_up[k];
               else if (md_load_skid) md_q <= sd_q;
               if (sd_load)           sd_q <= d_up[k];
            end
         end
      end else begin : g_keep
         // NOTE: payload registers carry no reset; the valid bits alone decide whether their contents mean anything.
         always_ff @(posedge clk) begin
            if (!flush) begin
               if (md_load_up)        md_q <= d_up[k];
               else if (md_load_skid) md_q <= sd_q;
               if (sd_load)           sd_q <= d_up[k];
            end
         end
      end

      assign mv[k] = mv_q;
      assign sv[k] = sv_q;
      assign md[k] = md_q;
   end

   assign in_ready  = !sv[0] && !flush;
   assign out_valid = mv[DEPTH-1] && !flush;
   assign out_data  = md[DEPTH-1];

   // NOTE: the accumulator gets its default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      occupancy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occupancy = occupancy + OCC_W'(mv[k]) + OCC_W'(sv[k]);
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: directed stream/backpressure/flush/reset on DEPTH=2, random stress on DEPTH=3,
// and a DEPTH=1 CLEAR_DATA=0 variant, each compared against a queue-based reference.
module tb_pipe_stage_elastic;

   logic        clk, rst_n, flush;

   logic        v1, rdy1, ov1, r1;
   logic [15:0] d1, od1;
   logic [1:0]  occ1;

   logic        v2, rdy2, ov2, r2;
   logic [15:0] d2, od2;
   logic [2:0]  occ2;

   logic        v3, rdy3, ov3, r3;
   logic [15:0] d3, od3;
   logic [2:0]  occ3;

   int tests = 0;
   int fails = 0;
   int j, k, pops, lowrun;
   logic [15:0] q3 [$];
   logic [15:0] q1 [$];

   pipe_stage_elastic #(.DATA_W(16), .DEPTH(1), .CLEAR_DATA(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(v1), .in_ready(rdy1), .in_data(d1),
      .out_valid(ov1), .out_ready(r1), .out_data(od1), .occupancy(occ1));

   pipe_stage_elastic #(.DATA_W(16), .DEPTH(2), .CLEAR_DATA(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(v2), .in_ready(rdy2), .in_data(d2),
      .out_valid(ov2), .out_ready(r2), .out_data(od2), .occupancy(occ2));

   pipe_stage_elastic #(.DATA_W(16), .DEPTH(3), .CLEAR_DATA(1'b1)) u3 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(v3), .in_ready(rdy3), .in_data(d3),
      .out_valid(ov3), .out_ready(r3), .out_data(od3), .occupancy(occ3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      v1 = 1'b0; d1 = '0; r1 = 1'b0;
      v2 = 1'b0; d2 = '0; r2 = 1'b0;
      v3 = 1'b0; d3 = '0; r3 = 1'b0;

      // reset state
      @(negedge clk); #1;
      check("reset_in_ready", 32'(rdy2), 1);
      check("reset_out_valid", 32'(ov2), 0);
      check("reset_out_data", 32'(od2), 0);
      check("reset_occ", 32'(occ2), 0);
      rst_n = 1'b1;

      // stream of 1..8 with out_ready held high
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         v2 = (c < 8); d2 = 16'(c + 1); r2 = 1'b1;
         #1;
         check("stream_in_ready", 32'(rdy2), 1);
         check("stream_out_valid", 32'(ov2), 32'(c >= 2 && c < 10));
         if (c >= 2 && c < 10) check("stream_out_data", 32'(od2), 32'(c - 1));
         if (c >= 2 && c < 8)  check("stream_occ", 32'(occ2), 2);
      end

      // backpressure: offer A0..A5, each held until accepted
      j = 0; k = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         v2 = (j < 6); d2 = 16'(16'hA0 + j); r2 = (c >= 6);
         #1;
         if (c < 4) check("bp_in_ready_open", 32'(rdy2), 1);
         if (c >= 4 && c <= 6) check("bp_in_ready_full", 32'(rdy2), 0);
         if (c == 4 || c == 5) check("bp_occ_full", 32'(occ2), 4);
         if (c == 8) check("bp_in_ready_reopen", 32'(rdy2), 1);
         if (ov2 && r2) begin
            check("bp_order", 32'(od2), 32'(16'hA0 + k));
            k++;
         end
         if (v2 && rdy2) j++;
      end
      check("bp_all_delivered", 32'(k), 6);

      // flush with three entries in flight and 0x55 offered
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         v2 = 1'b1; d2 = 16'(16'h20 + c); r2 = 1'b0;
      end
      @(negedge clk);
      v2 = 1'b1; d2 = 16'h55; flush = 1'b1;
      #1;
      check("flush_occ_before", 32'(occ2), 3);
      check("flush_in_ready", 32'(rdy2), 0);
      check("flush_out_valid", 32'(ov2), 0);
      @(negedge clk);
      flush = 1'b0; v2 = 1'b0; r2 = 1'b1;
      #1;
      check("flush_occ_after", 32'(occ2), 0);
      check("flush_out_valid_after", 32'(ov2), 0);
      check("flush_out_data_cleared", 32'(od2), 0);
      @(negedge clk);
      v2 = 1'b1; d2 = 16'h11;
      @(negedge clk);
      v2 = 1'b0;
      #1;
      check("post_flush_latency", 32'(ov2), 0);
      @(negedge clk); #1;
      check("post_flush_valid", 32'(ov2), 1);
      check("post_flush_data", 32'(od2), 32'h11);

      // asynchronous reset between edges with two entries held
      @(negedge clk);
      v2 = 1'b1; d2 = 16'h1; r2 = 1'b1;
      @(negedge clk);
      d2 = 16'h2;
      @(negedge clk);
      v2 = 1'b0;
      #1;
      check("arst_occ_before", 32'(occ2), 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(ov2), 0);
      check("arst_occ", 32'(occ2), 0);
      check("arst_out_data", 32'(od2), 0);
      check("arst_in_ready", 32'(rdy2), 1);
      @(negedge clk);
      rst_n = 1'b1; v2 = 1'b1; d2 = 16'h7;
      #1;
      check("arst_release_empty", 32'(ov2), 0);
      @(negedge clk);
      v2 = 1'b0;
      #1;
      check("arst_item_latency", 32'(ov2), 0);
      @(negedge clk); #1;
      check("arst_item_valid", 32'(ov2), 1);
      check("arst_item_data", 32'(od2), 32'h7);

      // random stress on DEPTH=3 against an in-order queue
      q3.delete();
      for (int c = 0; c < 10010; c++) begin
         @(negedge clk);
         if (c < 10000) begin
            v3 = 1'($urandom_range(0, 1));
            d3 = 16'($urandom);
            r3 = 1'($urandom_range(0, 1));
         end else begin
            v3 = 1'b0; r3 = 1'b1;
         end
         #1;
         check("stress_occ", 32'(occ3), 32'(q3.size()));
         check("stress_occ_bound", 32'(occ3 <= 3'd6), 1);
         if (ov3) begin
            if (q3.size() == 0) begin
               check("stress_spurious_valid", 32'(ov3), 0);
            end else begin
               check("stress_data", 32'(od3), 32'(q3[0]));
               if (r3) void'(q3.pop_front());
            end
         end
         if (v3 && rdy3) q3.push_back(d3);
      end
      check("stress_drained", 32'(q3.size()), 0);

      // DEPTH=1, CLEAR_DATA=0: payload survives flush
      @(negedge clk);
      v1 = 1'b1; d1 = 16'h3C; r1 = 1'b0;
      @(negedge clk);
      v1 = 1'b0; flush = 1'b1;
      #1;
      check("v1_flush_out_valid", 32'(ov1), 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("v1_after_flush_valid", 32'(ov1), 0);
      check("v1_after_flush_data_kept", 32'(od1), 32'h3C);
      check("v1_after_flush_occ", 32'(occ1), 0);

      // alternating out_ready: one entry per two cycles, in_ready never low twice in a row
      q1.delete(); pops = 0; lowrun = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         v1 = 1'b1; d1 = 16'(c + 1); r1 = (c % 2 == 1);
         #1;
         lowrun = rdy1 ? 0 : lowrun + 1;
         check("v1_in_ready_not_stuck", 32'(lowrun <= 1), 1);
         if (ov1 && r1) begin
            check("v1_order", 32'(od1), (q1.size() != 0) ? 32'(q1[0]) : 32'hFFFF_FFFF);
            if (q1.size() != 0) void'(q1.pop_front());
            pops++;
         end
         if (v1 && rdy1) q1.push_back(d1);
      end
      check("v1_throughput", 32'(pops), 10);
      v1 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
